// File: rtl/fifo_rd_packer.sv
// Packs PACK show-ahead FIFO words into one wide valid/ready word; partial words flush after TIMEOUT idle clocks.
// Optional statistics counters are enabled with `define PACKER_STATS_EN.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int PACK       = 2,
  parameter int LOG2PACK   = 1,
  parameter int TIMEOUT    = 64,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                         clock,
  input  logic                         sclr,
  input  logic [DATA_WIDTH-1:0]        fifo_q,
  input  logic                         fifo_rdempty,
  output logic                         fifo_rdreq,
  output logic [DATA_WIDTH*PACK-1:0]   out_data,
  output logic [PACK-1:0]              out_keep,
  output logic                         out_valid,
`ifdef PACKER_STATS_EN
  output logic [31:0]                  out_word_cnt,
  output logic [15:0]                  out_part_cnt,
`endif
  input  logic                         out_ready
);

  typedef enum logic {FILL, HOLD} state_e;

  localparam logic [LOG2PACK-1:0]  LAST_IDX = LOG2PACK'(PACK - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST  = (TIMEOUT == 0) ? '0 : CNT_WIDTH'(TIMEOUT - 1);

  state_e                       state_q, state_d;
  logic [LOG2PACK-1:0]          idx_q, idx_d;
  logic [CNT_WIDTH-1:0]         idle_q, idle_d;
  logic [DATA_WIDTH*PACK-1:0]   data_q, data_d;
  logic [PACK-1:0]              keep_q, keep_d;
  logic                         valid_q, valid_d;
  logic                         pop;
  logic                         accept;

  always_comb begin
    pop    = 1'b0;
    accept = (state_q == HOLD) && out_ready;
    if (!sclr) begin
      pop = (state_q == FILL) ? !fifo_rdempty : (out_ready && !fifo_rdempty);
    end

    state_d = state_q;
    idx_d   = idx_q;
    idle_d  = idle_q;
    data_d  = data_q;
    keep_d  = keep_q;
    valid_d = valid_q;

    case (state_q)
      FILL: begin
        if (pop) begin
          for (int unsigned i = 0; i < PACK; i++) begin
            if (idx_q == LOG2PACK'(i)) begin
              data_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_q;
              keep_d[i] = 1'b1;
            end
          end
          idle_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = HOLD;
            valid_d = 1'b1;
          end else begin
            idx_d = idx_q + LOG2PACK'(1);
          end
        end else if (idx_q == '0 || TIMEOUT == 0) begin
          idle_d = '0;
        end else if (idle_q == TO_LAST) begin
          // Flush the partial word; idx stays put and is cleared on HOLD exit.
          state_d = HOLD;
          valid_d = 1'b1;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + CNT_WIDTH'(1);
        end
      end
      HOLD: begin
        idle_d = '0;
        if (accept) begin
          state_d = FILL;
          valid_d = 1'b0;
          data_d  = '0;
          if (pop) begin
            data_d[DATA_WIDTH-1:0] = fifo_q;
            keep_d = PACK'(1);
            idx_d  = LOG2PACK'(1);
          end else begin
            keep_d = '0;
            idx_d  = '0;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      state_q <= FILL;
      idx_q   <= '0;
      idle_q  <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      idle_q  <= idle_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      valid_q <= valid_d;
    end
  end

  assign fifo_rdreq = pop;
  assign out_data   = data_q;
  assign out_keep   = keep_q;
  assign out_valid  = valid_q;

`ifdef PACKER_STATS_EN
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [15:0] part_cnt_q, part_cnt_d;

  always_comb begin
    word_cnt_d = word_cnt_q;
    part_cnt_d = part_cnt_q;
    if (accept) begin
      word_cnt_d = word_cnt_q + 32'd1;
      if (keep_q != '1 && part_cnt_q != 16'hFFFF) begin
        part_cnt_d = part_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      word_cnt_q <= '0;
      part_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      part_cnt_q <= part_cnt_d;
    end
  end

  assign out_word_cnt = word_cnt_q;
  assign out_part_cnt = part_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer (DATA_WIDTH=32, PACK=2, TIMEOUT=8) with a queue-based show-ahead FIFO model.
module tb_fifo_rd_packer;

  logic        clock;
  logic        sclr;
  logic [31:0] fifo_q;
  logic        fifo_rdempty;
  logic        fifo_rdreq;
  logic [63:0] out_data;
  logic [1:0]  out_keep;
  logic        out_valid;
  logic        out_ready;
`ifdef PACKER_STATS_EN
  logic [31:0] out_word_cnt;
  logic [15:0] out_part_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int underflow = 0;
  logic [31:0] fq[$];

  fifo_rd_packer #(
    .DATA_WIDTH(32),
    .PACK(2),
    .LOG2PACK(1),
    .TIMEOUT(8),
    .CNT_WIDTH(8)
  ) dut (
    .clock(clock),
    .sclr(sclr),
    .fifo_q(fifo_q),
    .fifo_rdempty(fifo_rdempty),
    .fifo_rdreq(fifo_rdreq),
    .out_data(out_data),
    .out_keep(out_keep),
    .out_valid(out_valid),
`ifdef PACKER_STATS_EN
    .out_word_cnt(out_word_cnt),
    .out_part_cnt(out_part_cnt),
`endif
    .out_ready(out_ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_fifo();
    fifo_rdempty = (fq.size() == 0);
    fifo_q = (fq.size() != 0) ? fq[0] : 32'h0;
  endtask

  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    drive_fifo();
    #1;
  endtask

  // Pops the model FIFO when the DUT asserted fifo_rdreq in the cycle just ended.
  task automatic tick();
    logic req;
    logic [31:0] dummy;
    req = fifo_rdreq;
    @(posedge clock);
    #1;
    if (req) begin
      if (fq.size() == 0) underflow++;
      else dummy = fq.pop_front();
    end
    drive_fifo();
    #1;
  endtask

  task automatic test_reset();
    sclr = 1'b1;
    out_ready = 1'b0;
    fq.push_back(32'hDEAD_BEEF);
    drive_fifo();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (fifo_rdreq !== 1'b0) begin failures++; $display("FAIL reset_rdreq cyc=%0d got=%b exp=0", i, fifo_rdreq); end
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid cyc=%0d got=%b exp=0", i, out_valid); end
      checks++;
      if (out_keep !== 2'b00) begin failures++; $display("FAIL reset_keep cyc=%0d got=%b exp=00", i, out_keep); end
      checks++;
      if (out_data !== 64'h0) begin failures++; $display("FAIL reset_data cyc=%0d got=%h exp=0", i, out_data); end
    end
    fq.delete();
    drive_fifo();
    sclr = 1'b0;
    tick();
  endtask

  task automatic test_full_pack();
    out_ready = 1'b1;
    push(32'd1); push(32'd2); push(32'd3); push(32'd4);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL pack_valid_c1 got=%b exp=0", out_valid); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h00000002_00000001 || out_keep !== 2'b11) begin
      failures++; $display("FAIL pack_word1 got v=%b d=%h k=%b exp v=1 d=0000000200000001 k=11", out_valid, out_data, out_keep);
    end
    checks++;
    if (fifo_rdreq !== 1'b1) begin failures++; $display("FAIL pack_accept_pop got=%b exp=1", fifo_rdreq); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_keep !== 2'b01) begin
      failures++; $display("FAIL pack_refill got v=%b k=%b exp v=0 k=01", out_valid, out_keep);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h00000004_00000003 || out_keep !== 2'b11) begin
      failures++; $display("FAIL pack_word2 got v=%b d=%h k=%b exp v=1 d=0000000400000003 k=11", out_valid, out_data, out_keep);
    end
    checks++;
    if (fifo_rdreq !== 1'b0) begin failures++; $display("FAIL pack_empty_rdreq got=%b exp=0", fifo_rdreq); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_keep !== 2'b00 || out_data !== 64'h0) begin
      failures++; $display("FAIL pack_drain got v=%b d=%h k=%b exp v=0 d=0 k=00", out_valid, out_data, out_keep);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push(32'd5); push(32'd6); push(32'd7);
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 64'h00000006_00000005 || fifo_rdreq !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got v=%b d=%h rq=%b exp v=1 d=0000000600000005 rq=0", i, out_valid, out_data, fifo_rdreq);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (fifo_rdreq !== 1'b1) begin failures++; $display("FAIL bp_release_pop got=%b exp=1", fifo_rdreq); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_keep !== 2'b01 || fq.size() != 0) begin
      failures++; $display("FAIL bp_after got v=%b k=%b left=%0d exp v=0 k=01 left=0", out_valid, out_keep, fq.size());
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_idle cyc=%0d got=%b exp=0", i, out_valid); end
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h00000000_00000007 || out_keep !== 2'b01) begin
      failures++; $display("FAIL bp_flush got v=%b d=%h k=%b exp v=1 d=0000000000000007 k=01", out_valid, out_data, out_keep);
    end
    tick();
  endtask

  task automatic test_partial_flush();
    out_ready = 1'b0;
    push(32'hA5A5A5A5);
    tick();
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_early cyc=%0d got=%b exp=0", i, out_valid); end
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h00000000_A5A5A5A5 || out_keep !== 2'b01) begin
      failures++; $display("FAIL flush_word got v=%b d=%h k=%b exp v=1 d=00000000a5a5a5a5 k=01", out_valid, out_data, out_keep);
    end
    tick(); tick();
    checks++;
    if (out_valid !== 1'b1 || out_keep !== 2'b01) begin
      failures++; $display("FAIL flush_hold got v=%b k=%b exp v=1 k=01", out_valid, out_keep);
    end
    out_ready = 1'b1;
    #1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_keep !== 2'b00) begin
      failures++; $display("FAIL flush_accept got v=%b k=%b exp v=0 k=00", out_valid, out_keep);
    end
  endtask

  task automatic test_timeout_race();
    out_ready = 1'b0;
    push(32'h1111_0000);
    tick();
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL race_pre got=%b exp=0", out_valid); end
    push(32'h2222_0000);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h22220000_11110000 || out_keep !== 2'b11) begin
      failures++; $display("FAIL race_word got v=%b d=%h k=%b exp v=1 d=2222000011110000 k=11", out_valid, out_data, out_keep);
    end
    out_ready = 1'b1;
    #1;
    tick();
  endtask

`ifdef PACKER_STATS_EN
  task automatic test_stats();
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    #1;
    test_full_pack();
    test_partial_flush();
    checks++;
    if (out_word_cnt !== 32'd3 || out_part_cnt !== 16'd1) begin
      failures++; $display("FAIL stats_cnt got w=%0d p=%0d exp w=3 p=1", out_word_cnt, out_part_cnt);
    end
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    #1;
    checks++;
    if (out_word_cnt !== 32'd0 || out_part_cnt !== 16'd0) begin
      failures++; $display("FAIL stats_clr got w=%0d p=%0d exp 0 0", out_word_cnt, out_part_cnt);
    end
  endtask
`endif

  task automatic test_no_underflow();
    checks++;
    if (underflow !== 0) begin failures++; $display("FAIL rdreq_while_empty got=%0d exp=0", underflow); end
  endtask

  initial begin
    sclr = 1'b1;
    out_ready = 1'b0;
    fifo_q = '0;
    fifo_rdempty = 1'b1;
    #2;
    test_reset();
    test_full_pack();
    test_backpressure();
    test_partial_flush();
    test_timeout_race();
`ifdef PACKER_STATS_EN
    test_stats();
`endif
    test_no_underflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
